sirv_gnrl_ram_itcm_2p: RTL

- Next-generation ITCM SRAM wrapper for the E203 core: one single-ported block-RAM array shared by two requesters.
- Port A carries core instruction fetch and load/store traffic; port B carries the ISP/debug loader.
- Adds the following: a fixed-priority arbiter with a starvation guard, an optional post-reset clear sequencer, an optional output register stage, and valid strobes on read data.

---
 rtl/sirv_gnrl_ram_itcm_2p_if.sv | 46 ++++
 rtl/sirv_gnrl_ram_itcm_2p.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_gnrl_ram_itcm_2p_if.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_ram_itcm_2p_if
// Bus bundle for the two-requester ITCM RAM wrapper.
//   Port A (core fetch / load-store): a_cs, a_we, a_addr, a_wem, a_din in;
//                                     a_ready, a_dout, a_rvalid out.
//   Port B (ISP / debug loader):      b_req, b_we, b_addr, b_wem, b_din in;
//                                     b_ready, b_dout, b_rvalid out.
// master modport is the requester side, slave modport is the RAM wrapper.
// ---------------------------------------------------------------------------
interface sirv_gnrl_ram_itcm_2p_if #(
    parameter int AW = 13,
    parameter int DW = 64,
    parameter int MW = DW / 8
);
    logic          a_cs;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [MW-1:0] a_wem;
    logic [DW-1:0] a_din;
    logic          a_ready;
    logic [DW-1:0] a_dout;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [MW-1:0] b_wem;
    logic [DW-1:0] b_din;
    logic          b_ready;
    logic [DW-1:0] b_dout;
    logic          b_rvalid;

    modport master (
        output a_cs, a_we, a_addr, a_wem, a_din,
        input  a_ready, a_dout, a_rvalid,
        output b_req, b_we, b_addr, b_wem, b_din,
        input  b_ready, b_dout, b_rvalid
    );

    modport slave (
        input  a_cs, a_we, a_addr, a_wem, a_din,
        output a_ready, a_dout, a_rvalid,
        input  b_req, b_we, b_addr, b_wem, b_din,
        output b_ready, b_dout, b_rvalid
    );
endinterface

// File: rtl/sirv_gnrl_ram_itcm_2p.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_ram_itcm_2p
// Single-ported ITCM array shared by two requesters. Port A has fixed
// priority; port B is guaranteed a slot after STARVE consecutive denials.
// An optional clear sequencer zeroes the array after reset, and an optional
// output register adds one cycle of read latency.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of the A/B request/response bundle
//   init_busy : high while the post-reset clear sequence runs
// ---------------------------------------------------------------------------
module sirv_gnrl_ram_itcm_2p #(
    parameter int DP     = 8192,
    parameter int DW     = 64,
    parameter int MW     = DW / 8,
    parameter int AW     = 13,
    parameter int OREG   = 0,
    parameter int CLR_EN = 1,
    parameter int STARVE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sirv_gnrl_ram_itcm_2p_if.slave        bus,
    output logic                          init_busy
);

    localparam int             SW       = $clog2(STARVE + 1);
    localparam logic [SW-1:0]  STARVE_L = SW'(STARVE);
    localparam logic [AW:0]    DP_L     = (AW + 1)'(DP);
    localparam logic [AW-1:0]  LAST_L   = AW'(DP - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          run;
    logic          forced;
    logic          a_acc;
    logic          b_acc;

    // Single array access point, shared by clear, port B and port A
    logic          acc_en;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [MW-1:0] acc_wem;
    logic [DW-1:0] acc_din;
    logic          acc_in;

    logic [DW-1:0] mem_q [0:DP-1];
    logic [DW-1:0] rdat_q;
    logic          rd_a_q;
    logic          rd_b_q;
    logic          rd_oob_q;
    logic [DW-1:0] rd_word;

    assign run       = (state_q == ST_RUN);
    assign forced    = (starve_q == STARVE_L);
    assign init_busy = ~run;

    // rst_n gating keeps the readies low during reset even when the wrapper
    // resets straight into RUN (no clear sequence).
    assign bus.a_ready = run & rst_n & ~forced;
    assign bus.b_ready = run & rst_n & bus.b_req & (~bus.a_cs | forced);

    assign a_acc = bus.a_cs  & bus.a_ready;
    assign b_acc = bus.b_req & bus.b_ready;

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= (CLR_EN != 0) ? ST_CLEAR : ST_RUN;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // ---- next state: clear counter and starvation counter ------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_L) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // Count only denied cycles of a pending B request; a granted
                // slot or an idle B resets the count.
                if (bus.b_req && !bus.b_ready) begin
                    if (!forced) starve_d = starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ---- access mux: clear has the array to itself; A and B never overlap --
    always_comb begin
        acc_en   = 1'b0;
        acc_we   = 1'b0;
        acc_addr = '0;
        acc_wem  = '0;
        acc_din  = '0;
        if (!run) begin
            acc_en   = 1'b1;
            acc_we   = 1'b1;
            acc_addr = cnt_q;
            acc_wem  = '1;
            acc_din  = '0;
        end else if (b_acc) begin
            acc_en   = 1'b1;
            acc_we   = bus.b_we;
            acc_addr = bus.b_addr;
            acc_wem  = bus.b_wem;
            acc_din  = bus.b_din;
        end else if (a_acc) begin
            acc_en   = 1'b1;
            acc_we   = bus.a_we;
            acc_addr = bus.a_addr;
            acc_wem  = bus.a_wem;
            acc_din  = bus.a_din;
        end
    end

    assign acc_in = ({1'b0, acc_addr} < DP_L);

    // ---- array: byte-masked write or synchronous read ----------------------
    always_ff @(posedge clk) begin
        if (acc_en && acc_in) begin
            if (acc_we) begin
                for (int i = 0; i < MW; i++) begin
                    if (acc_wem[i]) mem_q[acc_addr][i*8 +: 8] <= acc_din[i*8 +: 8];
                end
            end else begin
                rdat_q <= mem_q[acc_addr];
            end
        end
    end

    // ---- read tracking: which port owns the word coming out of the array ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            rd_oob_q <= 1'b0;
        end else begin
            rd_a_q   <= a_acc & ~bus.a_we;
            rd_b_q   <= b_acc & ~bus.b_we;
            rd_oob_q <= ~acc_in;
        end
    end

    // Out-of-range reads never touch the array, so rdat_q is stale for them.
    assign rd_word = rd_oob_q ? '0 : rdat_q;

    // ---- output stage ------------------------------------------------------
    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] a_out_q;
            logic [DW-1:0] b_out_q;
            logic          a_rv_q;
            logic          b_rv_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rv_q  <= 1'b0;
                    b_rv_q  <= 1'b0;
                    a_out_q <= '0;
                    b_out_q <= '0;
                end else begin
                    a_rv_q <= rd_a_q;
                    b_rv_q <= rd_b_q;
                    if (rd_a_q) a_out_q <= rd_word;
                    if (rd_b_q) b_out_q <= rd_word;
                end
            end

            assign bus.a_dout   = a_out_q;
            assign bus.b_dout   = b_out_q;
            assign bus.a_rvalid = a_rv_q;
            assign bus.b_rvalid = b_rv_q;
        end else begin : g_noreg
            // The array output is shared, so each port keeps its own copy of
            // its last read word and shows it whenever the array is not
            // presenting fresh data for that port.
            logic [DW-1:0] a_hold_q;
            logic [DW-1:0] b_hold_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hold_q <= '0;
                    b_hold_q <= '0;
                end else begin
                    if (rd_a_q) a_hold_q <= rd_word;
                    if (rd_b_q) b_hold_q <= rd_word;
                end
            end

            assign bus.a_dout   = rd_a_q ? rd_word : a_hold_q;
            assign bus.b_dout   = rd_b_q ? rd_word : b_hold_q;
            assign bus.a_rvalid = rd_a_q;
            assign bus.b_rvalid = rd_b_q;
        end
    endgenerate

endmodule
